// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two single-entry request buffers (ALU, load) feeding one
// registered write port, with pending-write hazard query. Define RF_WB_ROUND_ROBIN_EN for RR.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [4:0]  addr0_i,
  input  logic [4:0]  addr1_i,
  input  logic [31:0] data0_i,
  input  logic [31:0] data1_i,
  output logic        rdy0_o,
  output logic        rdy1_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_a3_o,
  output logic [31:0] rf_wd_o,
  input  logic [4:0]  qa1_i,
  input  logic [4:0]  qa2_i,
  output logic        hazard_o,
  output logic [15:0] wr_cnt_o
);

  logic        buf0_valid_q, buf0_valid_d;
  logic        buf1_valid_q, buf1_valid_d;
  logic [4:0]  buf0_addr_q, buf0_addr_d;
  logic [4:0]  buf1_addr_q, buf1_addr_d;
  logic [31:0] buf0_data_q, buf0_data_d;
  logic [31:0] buf1_data_q, buf1_data_d;

  logic        we_q, we_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        load0, load1;
  logic        gnt;
  logic        gnt_sel;  // 1 = requester 1 (load) wins this edge

  assign rdy0_o = ~buf0_valid_q;
  assign rdy1_o = ~buf1_valid_q;

  // Writes to x0 are accepted but never buffered.
  assign load0 = req0_i & ~buf0_valid_q & (addr0_i != 5'd0);
  assign load1 = req1_i & ~buf1_valid_q & (addr1_i != 5'd0);

  assign gnt = ~dbg_i & (buf0_valid_q | buf1_valid_q);

`ifdef RF_WB_ROUND_ROBIN_EN
  // rr_q names the requester that wins the next contention; reset 0 favours the ALU,
  // i.e. the load side is treated as the last one granted.
  logic rr_q, rr_d;

  always_comb begin
    gnt_sel = buf1_valid_q;
    if (buf0_valid_q && buf1_valid_q) begin
      gnt_sel = rr_q;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt) begin
      rr_d = ~gnt_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: the load requester wins whenever its buffer is valid.
  assign gnt_sel = buf1_valid_q;
`endif

  always_comb begin
    buf0_valid_d = buf0_valid_q;
    buf0_addr_d  = buf0_addr_q;
    buf0_data_d  = buf0_data_q;
    buf1_valid_d = buf1_valid_q;
    buf1_addr_d  = buf1_addr_q;
    buf1_data_d  = buf1_data_q;
    // A buffer is either empty (may load) or valid (may be granted), never both.
    if (gnt && !gnt_sel) begin
      buf0_valid_d = 1'b0;
    end
    if (gnt && gnt_sel) begin
      buf1_valid_d = 1'b0;
    end
    if (load0) begin
      buf0_valid_d = 1'b1;
      buf0_addr_d  = addr0_i;
      buf0_data_d  = data0_i;
    end
    if (load1) begin
      buf1_valid_d = 1'b1;
      buf1_addr_d  = addr1_i;
      buf1_data_d  = data1_i;
    end
  end

  always_comb begin
    we_d  = gnt;
    a3_d  = a3_q;
    wd_d  = wd_q;
    cnt_d = cnt_q;
    if (gnt) begin
      a3_d  = gnt_sel ? buf1_addr_q : buf0_addr_q;
      wd_d  = gnt_sel ? buf1_data_q : buf0_data_q;
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf0_valid_q <= 1'b0;
      buf0_addr_q  <= 5'd0;
      buf0_data_q  <= 32'd0;
      buf1_valid_q <= 1'b0;
      buf1_addr_q  <= 5'd0;
      buf1_data_q  <= 32'd0;
      we_q         <= 1'b0;
      a3_q         <= 5'd0;
      wd_q         <= 32'd0;
      cnt_q        <= 16'd0;
    end else begin
      buf0_valid_q <= buf0_valid_d;
      buf0_addr_q  <= buf0_addr_d;
      buf0_data_q  <= buf0_data_d;
      buf1_valid_q <= buf1_valid_d;
      buf1_addr_q  <= buf1_addr_d;
      buf1_data_q  <= buf1_data_d;
      we_q         <= we_d;
      a3_q         <= a3_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rf_we_o  = we_q;
  assign rf_a3_o  = a3_q;
  assign rf_wd_o  = wd_q;
  assign wr_cnt_o = cnt_q;

  function automatic logic pending_match(input logic [4:0] qa);
    logic hit;
    hit = (buf0_valid_q && (qa == buf0_addr_q)) ||
          (buf1_valid_q && (qa == buf1_addr_q)) ||
          (we_q && (qa == a3_q));
    return (qa != 5'd0) && hit;
  endfunction

  always_comb begin
    hazard_o = pending_match(qa1_i) | pending_match(qa2_i);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed table-driven bench for rf_wb_arbiter, plus reset-drop and counter-wrap sequences.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_i;
  logic        req0_i, req1_i;
  logic [4:0]  addr0_i, addr1_i;
  logic [31:0] data0_i, data1_i;
  logic        rdy0_o, rdy1_o;
  logic        rf_we_o;
  logic [4:0]  rf_a3_o;
  logic [31:0] rf_wd_o;
  logic [4:0]  qa1_i, qa2_i;
  logic        hazard_o;
  logic [15:0] wr_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .dbg_i    (dbg_i),
    .req0_i   (req0_i),
    .req1_i   (req1_i),
    .addr0_i  (addr0_i),
    .addr1_i  (addr1_i),
    .data0_i  (data0_i),
    .data1_i  (data1_i),
    .rdy0_o   (rdy0_o),
    .rdy1_o   (rdy1_o),
    .rf_we_o  (rf_we_o),
    .rf_a3_o  (rf_a3_o),
    .rf_wd_o  (rf_wd_o),
    .qa1_i    (qa1_i),
    .qa2_i    (qa2_i),
    .hazard_o (hazard_o),
    .wr_cnt_o (wr_cnt_o)
  );

  typedef struct {
    logic        r0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        r1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        dbg;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_hz;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVec = 22;
  vec_t tbl [NVec];

`ifdef RF_WB_ROUND_ROBIN_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  function automatic vec_t mk(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic dbg, input logic [4:0] q1, input logic [4:0] q2,
                              input logic e_rdy0, input logic e_rdy1, input logic e_we,
                              input logic [4:0] e_a3, input logic [31:0] e_wd,
                              input logic e_hz, input logic [15:0] e_cnt);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
    v.dbg = dbg; v.q1 = q1; v.q2 = q2;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_we = e_we; v.e_a3 = e_a3;
    v.e_wd = e_wd; v.e_hz = e_hz; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_i  = v.r0;
    addr0_i = v.a0;
    data0_i = v.d0;
    req1_i  = v.r1;
    addr1_i = v.a1;
    data1_i = v.d1;
    dbg_i   = v.dbg;
    qa1_i   = v.q1;
    qa2_i   = v.q2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  ha3;
    logic [31:0] hwd;
    logic [31:0] w20;
    logic        bad;
    int          g;

    // Output-stage value held after the contention pair (last issued write).
    ha3 = RrMode ? 5'd4 : 5'd3;
    hwd = RrMode ? 32'h44 : 32'h33;
    w20 = RrMode ? 32'h61 : 32'h60;

    tbl[0]  = mk(1, 3, 32'h33, 1, 4, 32'h44, 0, 3, 4,  0, 0, 0, 0, 32'h0, 1, 0);
    if (RrMode) tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 0, 1, 3, 32'h33, 1, 1);
    else        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0,  0, 1, 1, 4, 32'h44, 1, 1);
    if (RrMode) tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 1, 4, 32'h44, 0, 2);
    else        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 1, 3, 32'h33, 1, 2);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, ha3, hwd, 0, 2);
    tbl[4]  = mk(1, 5, 32'h1234, 0, 0, 0, 0, 5, 0,  0, 1, 0, ha3, hwd, 1, 2);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 0,  1, 1, 1, 5, 32'h1234, 1, 3);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 0,  1, 1, 0, 5, 32'h1234, 0, 3);
    tbl[7]  = mk(1, 0, 32'h99, 0, 0, 0, 0, 0, 5,  1, 1, 0, 5, 32'h1234, 0, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 5, 32'h1234, 0, 3);
    tbl[9]  = mk(1, 7, 32'h77, 0, 0, 0, 0, 7, 0,  0, 1, 0, 5, 32'h1234, 1, 3);
    tbl[10] = mk(1, 8, 32'h88, 0, 0, 0, 1, 7, 0,  0, 1, 0, 5, 32'h1234, 1, 3);
    for (int i = 11; i < 15; i++) begin
      tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 1, 0, 5, 32'h1234, 1, 3);
    end
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 1, 7, 32'h77, 1, 4);
    tbl[16] = mk(0, 0, 0, 1, 9, 32'h99, 1, 9, 0,  1, 0, 0, 7, 32'h77, 1, 4);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 9, 0,  1, 1, 1, 9, 32'h99, 1, 5);
    tbl[18] = mk(1, 6, 32'h60, 1, 6, 32'h61, 0, 6, 0,  0, 0, 0, 9, 32'h99, 1, 5);
    if (RrMode) tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0,  1, 0, 1, 6, 32'h60, 1, 6);
    else        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0,  0, 1, 1, 6, 32'h61, 1, 6);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0,  1, 1, 1, 6, w20, 1, 7);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0,  1, 1, 0, 6, w20, 0, 7);

    // Reset state
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 5, 3,  0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("reset.rdy0", 0, rdy0_o, 1);
    chk("reset.rdy1", 0, rdy1_o, 1);
    chk("reset.we", 0, rf_we_o, 0);
    chk("reset.a3", 0, rf_a3_o, 0);
    chk("reset.wd", 0, rf_wd_o, 0);
    chk("reset.cnt", 0, wr_cnt_o, 0);
    chk("reset.hazard", 0, hazard_o, 0);
    step();
    rst = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      drive(tbl[i]);
      step();
      chk("vec.rdy0", i, rdy0_o, tbl[i].e_rdy0);
      chk("vec.rdy1", i, rdy1_o, tbl[i].e_rdy1);
      chk("vec.we", i, rf_we_o, tbl[i].e_we);
      chk("vec.a3", i, rf_a3_o, tbl[i].e_a3);
      chk("vec.wd", i, rf_wd_o, tbl[i].e_wd);
      chk("vec.hazard", i, hazard_o, tbl[i].e_hz);
      chk("vec.cnt", i, wr_cnt_o, tbl[i].e_cnt);
    end

    // Reset mid-operation: one write issuing, one still buffered.
    drive(mk(1, 10, 32'hA, 1, 11, 32'hB, 0, 10, 11,  0, 0, 0, 0, 0, 0, 0));
    step();
    req0_i = 1'b0;
    req1_i = 1'b0;
    step();
    chk("rst_mid.we_before", 0, rf_we_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid.rdy0", 0, rdy0_o, 1);
    chk("rst_mid.rdy1", 0, rdy1_o, 1);
    chk("rst_mid.we", 0, rf_we_o, 0);
    chk("rst_mid.a3", 0, rf_a3_o, 0);
    chk("rst_mid.wd", 0, rf_wd_o, 0);
    chk("rst_mid.cnt", 0, wr_cnt_o, 0);
    chk("rst_mid.hazard", 0, hazard_o, 0);
    step();
    step();
    rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rf_we_o) bad = 1'b1;
    end
    chk("rst_mid.no_write", 0, bad, 0);
    chk("rst_mid.cnt_after", 0, wr_cnt_o, 0);

    // Counter wrap: both requesters stream writes, one grant per cycle.
    drive(mk(1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    g = 0;
    for (int c = 0; c < 70000 && g < 65536; c++) begin
      step();
      if (rf_we_o) begin
        g++;
        if (g == 65535) chk("wrap.cnt_max", 0, wr_cnt_o, 32'hFFFF);
      end
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    chk("wrap.grants", 0, g, 65536);
    chk("wrap.cnt_zero", 0, wr_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
